// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: byte-stream valid/ready bus (in_data, in_valid from master; in_ready from slave)
interface aes_block_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles key then plaintext blocks from a byte stream; ports: clk, rst, in_if (byte bus), rekey, key_out/key_valid, pt_out/pt_valid, ct_valid (latency-matched), inflight, blk_cnt
module aes_block_loader #(
  parameter int PIPE_LAT = 10,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  aes_block_loader_if.slave   in_if,
  input  logic                rekey,
  output logic [127:0]        key_out,
  output logic                key_valid,
  output logic [127:0]        pt_out,
  output logic                pt_valid,
  output logic                ct_valid,
  output logic [6:0]          inflight,
  output logic [CNT_W-1:0]    blk_cnt
);
  typedef enum logic {KEY_LOAD, PT_LOAD} state_t;
  state_t              state;
  logic [3:0]          byte_cnt;
  logic [119:0]        sh;
  logic [PIPE_LAT-1:0] dly;
  logic                accept;
  assign in_if.in_ready = ~rst & ~rekey;
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign ct_valid       = dly[PIPE_LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KEY_LOAD;
      byte_cnt  <= '0;
      sh        <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      pt_out    <= '0;
      pt_valid  <= 1'b0;
      dly       <= '0;
      inflight  <= '0;
      blk_cnt   <= '0;
    end else if (rekey) begin
      state     <= KEY_LOAD;
      byte_cnt  <= '0;
      key_valid <= 1'b0;
      pt_valid  <= 1'b0;
      dly       <= '0;
      inflight  <= '0;
      blk_cnt   <= '0;
    end else begin
      pt_valid <= 1'b0;
      dly      <= PIPE_LAT'({dly, pt_valid});
      if (pt_valid != ct_valid)
        inflight <= pt_valid ? inflight + 7'd1 : inflight - 7'd1;
      if (ct_valid)
        blk_cnt <= blk_cnt + CNT_W'(1);
      if (accept) begin
        sh       <= {sh[111:0], in_if.in_data};
        byte_cnt <= byte_cnt + 4'd1;
        if (byte_cnt == 4'd15) begin
          if (state == KEY_LOAD) begin
            key_out   <= {sh, in_if.in_data};
            key_valid <= 1'b1;
            state     <= PT_LOAD;
          end else begin
            pt_out   <= {sh, in_if.in_data};
            pt_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
